// File: rtl/fruit_game_pkg.sv
// ---------------------------------------------------------------------------
// fruit_game_pkg
// Shared definitions for the fruit-catch game-flow controller:
//   - state encoding (3-bit, IDLE..LOSE)
//   - default game constants used as parameter defaults by the RTL
// ---------------------------------------------------------------------------
package fruit_game_pkg;

   localparam int STATE_W = 3;

   // Encodings are visible on the state output, so they are fixed explicitly.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_PAUSE = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;

   localparam int DEF_WIN_SCORE = 30;
   localparam int DEF_BUG_PEN   = 5;
   localparam int DEF_LIVES     = 3;
   localparam int DEF_TIME_S    = 60;

endpackage

// File: rtl/fruit_score_acc.sv
// ---------------------------------------------------------------------------
// fruit_score_acc
// Combinational next-score calculation for one PLAY cycle.
//   score     in  SCORE_W  current signed score
//   fruit_hit in  N_FRUIT  per-channel catch pulses, fruit i worth i+1
//   bug_hit   in  1        bug caught, subtracts BUG_PEN
//   nxt       out SCORE_W  score + gain - pen, saturated to the signed range
// ---------------------------------------------------------------------------
module fruit_score_acc
   import fruit_game_pkg::*;
#(
   parameter int N_FRUIT = 3,
   parameter int SCORE_W = 8,
   parameter int BUG_PEN = DEF_BUG_PEN
) (
   input  logic [SCORE_W-1:0] score,
   input  logic [N_FRUIT-1:0] fruit_hit,
   input  logic               bug_hit,
   output logic [SCORE_W-1:0] nxt
);

   // Two guard bits keep the raw sum from wrapping before it is clamped.
   localparam int SUM_W = SCORE_W + 2;
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((2 ** (SCORE_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

   logic signed [SUM_W-1:0] sum;

   // NOTE: combinational logic uses blocking assignments, and every path
   // assigns every output so no latch is inferred.
   always_comb begin
      sum = {{2{score[SCORE_W-1]}}, score};
      for (int i = 0; i < N_FRUIT; i++) begin
         if (fruit_hit[i]) sum = sum + SUM_W'(i + 1);
      end
      if (bug_hit) sum = sum - SUM_W'(BUG_PEN);

      if (sum > MAX_V)      nxt = MAX_V[SCORE_W-1:0];
      else if (sum < MIN_V) nxt = MIN_V[SCORE_W-1:0];
      else                  nxt = sum[SCORE_W-1:0];
   end

endmodule

// File: rtl/fruit_game_ctrl.sv
// ---------------------------------------------------------------------------
// fruit_game_ctrl
// Game-flow FSM for the fruit-catch VGA game: score, lives, countdown, pause.
//   clk        in  1        system clock
//   rst        in  1        synchronous, active-low reset
//   start_p    in  1        start / abort pulse
//   pause_p    in  1        pause toggle pulse
//   sec_tick   in  1        one pulse per second
//   fruit_hit  in  N_FRUIT  per-channel catch pulses
//   bug_hit    in  1        bug caught pulse
//   fruit_miss in  1        fruit hit the floor
//   state      out 3        IDLE=0 PLAY=1 PAUSE=2 WIN=3 LOSE=4
//   score      out SCORE_W  signed two's-complement score
//   lives      out LIVES_W  remaining lives
//   time_left  out TIME_W   seconds remaining
//   win        out 1        high while in WIN
//   over_p     out 1        one-cycle pulse on entry to WIN or LOSE
// All outputs are registered.
// ---------------------------------------------------------------------------
module fruit_game_ctrl
   import fruit_game_pkg::*;
#(
   parameter int N_FRUIT   = 3,
   parameter int SCORE_W   = 8,
   parameter int WIN_SCORE = DEF_WIN_SCORE,
   parameter int BUG_PEN   = DEF_BUG_PEN,
   parameter int LIVES     = DEF_LIVES,
   parameter int LIVES_W   = 2,
   parameter int TIME_S    = DEF_TIME_S,
   parameter int TIME_W    = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_p,
   input  logic               pause_p,
   input  logic               sec_tick,
   input  logic [N_FRUIT-1:0] fruit_hit,
   input  logic               bug_hit,
   input  logic               fruit_miss,
   output logic [STATE_W-1:0] state,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [TIME_W-1:0]  time_left,
   output logic               win,
   output logic               over_p
);

   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(TIME_S);

   state_t             st;
   logic [SCORE_W-1:0] nxt_score;
   logic [LIVES_W-1:0] lives_n;
   logic [TIME_W-1:0]  time_n;
   logic               win_c;
   logic               lose_c;

   fruit_score_acc #(
      .N_FRUIT (N_FRUIT),
      .SCORE_W (SCORE_W),
      .BUG_PEN (BUG_PEN)
   ) u_score_acc (
      .score     (score),
      .fruit_hit (fruit_hit),
      .bug_hit   (bug_hit),
      .nxt       (nxt_score)
   );

   // Candidate PLAY updates; counters stop at zero instead of wrapping.
   always_comb begin
      lives_n = (fruit_miss && lives != '0) ? lives - LIVES_W'(1) : lives;
      time_n  = (sec_tick && time_left != '0) ? time_left - TIME_W'(1) : time_left;
      win_c   = int'($signed(nxt_score)) >= WIN_SCORE;
      lose_c  = nxt_score[SCORE_W-1] || (lives_n == '0) || (time_n == '0);
   end

   assign state = st;

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st        <= ST_IDLE;
         score     <= '0;
         lives     <= LIVES_INIT;
         time_left <= TIME_INIT;
         win       <= 1'b0;
         over_p    <= 1'b0;
      end else begin
         over_p <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (start_p) begin
                  st        <= ST_PLAY;
                  score     <= '0;
                  lives     <= LIVES_INIT;
                  time_left <= TIME_INIT;
               end
            end
            ST_PLAY: begin
               if (start_p) begin
                  // Abort: this cycle's updates are dropped.
                  st <= ST_IDLE;
               end else begin
                  score     <= nxt_score;
                  lives     <= lives_n;
                  time_left <= time_n;
                  // Win is checked first so a simultaneous win/lose is a win.
                  if (win_c) begin
                     st     <= ST_WIN;
                     win    <= 1'b1;
                     over_p <= 1'b1;
                  end else if (lose_c) begin
                     st     <= ST_LOSE;
                     over_p <= 1'b1;
                  end else if (pause_p) begin
                     st <= ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (start_p)      st <= ST_IDLE;
               else if (pause_p) st <= ST_PLAY;
            end
            ST_WIN, ST_LOSE: begin
               if (start_p) begin
                  st        <= ST_IDLE;
                  score     <= '0;
                  lives     <= LIVES_INIT;
                  time_left <= TIME_INIT;
                  win       <= 1'b0;
               end
            end
            default: begin
               st  <= ST_IDLE;
               win <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fruit_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fruit_game_ctrl
// Directed scoreboard bench: each stimulus cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares once the DUT has
// registered that cycle. A second instance (SCORE_W=4, WIN_SCORE=100)
// exercises score saturation.
// ---------------------------------------------------------------------------
module tb_fruit_game_ctrl;

   localparam int I  = 0;
   localparam int PL = 1;
   localparam int PA = 2;
   localparam int W  = 3;
   localparam int L  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_p, pause_p, sec_tick, bug_hit, fruit_miss;
   logic [2:0] fruit_hit;
   logic [2:0] state;
   logic [7:0] score;
   logic [1:0] lives;
   logic [6:0] time_left;
   logic       win, over_p;

   logic       s_start, s_bug;
   logic [2:0] s_fh;
   logic [2:0] s_state;
   logic [3:0] s_score;
   logic [1:0] s_lives;
   logic [6:0] s_time;
   logic       s_win, s_over;

   always #5 clk = ~clk;

   fruit_game_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start_p    (start_p),
      .pause_p    (pause_p),
      .sec_tick   (sec_tick),
      .fruit_hit  (fruit_hit),
      .bug_hit    (bug_hit),
      .fruit_miss (fruit_miss),
      .state      (state),
      .score      (score),
      .lives      (lives),
      .time_left  (time_left),
      .win        (win),
      .over_p     (over_p)
   );

   fruit_game_ctrl #(.SCORE_W(4), .WIN_SCORE(100)) sat (
      .clk        (clk),
      .rst        (rst),
      .start_p    (s_start),
      .pause_p    (1'b0),
      .sec_tick   (1'b0),
      .fruit_hit  (s_fh),
      .bug_hit    (s_bug),
      .fruit_miss (1'b0),
      .state      (s_state),
      .score      (s_score),
      .lives      (s_lives),
      .time_left  (s_time),
      .win        (s_win),
      .over_p     (s_over)
   );

   typedef struct {
      int due;
      bit sel;
      int id;
      int st;
      int sc;
      int lv;
      int tm;
      bit ov;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_step = 0;
   int   total  = 0;
   int   bad    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation whose sampling edge has passed.
   always @(negedge clk) begin
      exp_t               e;
      logic signed [31:0] a_st, a_sc, a_lv, a_tm;
      logic               a_win, a_ov;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         if (!e.sel) begin
            a_st = 32'(state);   a_sc = 32'($signed(score));
            a_lv = 32'(lives);   a_tm = 32'(time_left);
            a_win = win;         a_ov = over_p;
         end else begin
            a_st = 32'(s_state); a_sc = 32'($signed(s_score));
            a_lv = 32'(s_lives); a_tm = 32'(s_time);
            a_win = s_win;       a_ov = s_over;
         end
         total++;
         if (a_st !== e.st || a_sc !== e.sc || a_lv !== e.lv || a_tm !== e.tm ||
             a_win !== (e.st == W) || a_ov !== e.ov) begin
            bad++;
            $display("FAIL step %0d (dut %0d): got st=%0d sc=%0d lv=%0d tm=%0d win=%b ov=%b, want st=%0d sc=%0d lv=%0d tm=%0d win=%b ov=%b",
                     e.id, e.sel, a_st, a_sc, a_lv, a_tm, a_win, a_ov,
                     e.st, e.sc, e.lv, e.tm, (e.st == W), e.ov);
         end
      end
   end

   task automatic idle_inputs();
      rst = 1'b1;
      start_p = 1'b0; pause_p = 1'b0; sec_tick = 1'b0;
      fruit_hit = 3'b000; bug_hit = 1'b0; fruit_miss = 1'b0;
      s_start = 1'b0; s_fh = 3'b000; s_bug = 1'b0;
   endtask

   // Drive one cycle and queue the outputs expected after the next edge.
   task automatic drv(input bit r, input bit sp, input bit pp, input bit tk,
                      input bit [2:0] fh, input bit bg, input bit ms, input bit sel,
                      input int est, input int esc, input int elv, input int etm,
                      input bit eov);
      exp_t e;
      rst = r;
      if (!sel) begin
         start_p = sp; pause_p = pp; sec_tick = tk;
         fruit_hit = fh; bug_hit = bg; fruit_miss = ms;
      end else begin
         s_start = sp; s_fh = fh; s_bug = bg;
      end
      e = '{due: cyc + 1, sel: sel, id: n_step, st: est, sc: esc, lv: elv, tm: etm, ov: eov};
      q.push_back(e);
      n_step++;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic p(input bit sp, input bit pp, input bit tk, input bit [2:0] fh,
                    input bit bg, input bit ms,
                    input int est, input int esc, input int elv, input int etm,
                    input bit eov);
      drv(1'b1, sp, pp, tk, fh, bg, ms, 1'b0, est, esc, elv, etm, eov);
   endtask

   task automatic s(input bit sp, input bit [2:0] fh, input bit bg,
                    input int est, input int esc, input bit eov);
      drv(1'b1, sp, 1'b0, 1'b0, fh, bg, 1'b0, 1'b1, est, esc, 3, 60, eov);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset held two cycles, then start.
      drv(1'b0, 0, 0, 0, 3'b000, 0, 0, 1'b0, I, 0, 3, 60, 0);
      drv(1'b0, 0, 0, 0, 3'b000, 0, 0, 1'b0, I, 0, 3, 60, 0);
      p(0, 0, 0, 3'b111, 1, 1, I, 0, 3, 60, 0);   // IDLE ignores game inputs
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);

      // Scoring: multi-hit and bug penalty.
      p(0, 0, 0, 3'b111, 0, 0, PL, 6, 3, 60, 0);
      p(0, 0, 0, 3'b011, 0, 0, PL, 9, 3, 60, 0);
      p(0, 0, 0, 3'b001, 0, 0, PL, 10, 3, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 16, 3, 60, 0);
      p(0, 0, 0, 3'b000, 1, 0, PL, 11, 3, 60, 0);

      // Climb to 28, then win exactly at 30.
      p(0, 0, 0, 3'b111, 0, 0, PL, 17, 3, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 23, 3, 60, 0);
      p(0, 0, 0, 3'b011, 0, 0, PL, 26, 3, 60, 0);
      p(0, 0, 0, 3'b010, 0, 0, PL, 28, 3, 60, 0);
      p(0, 0, 0, 3'b010, 0, 0, W, 30, 3, 60, 1);
      p(0, 0, 0, 3'b000, 0, 0, W, 30, 3, 60, 0);
      p(0, 0, 1, 3'b111, 1, 1, W, 30, 3, 60, 0);  // frozen in WIN
      p(1, 0, 0, 3'b000, 0, 0, I, 0, 3, 60, 0);
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);

      // Lose by misses; lives stop at zero.
      p(0, 0, 0, 3'b000, 0, 1, PL, 0, 2, 60, 0);
      p(0, 0, 0, 3'b000, 0, 1, PL, 0, 1, 60, 0);
      p(0, 0, 0, 3'b000, 0, 1, L, 0, 0, 60, 1);
      p(0, 0, 0, 3'b111, 0, 1, L, 0, 0, 60, 0);
      p(1, 0, 0, 3'b000, 0, 0, I, 0, 3, 60, 0);
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);

      // Lose by timer; time_left stops at zero.
      for (int i = 1; i <= 60; i++) begin
         p(0, 0, 1, 3'b000, 0, 0, (i == 60) ? L : PL, 0, 3, 60 - i, (i == 60));
      end
      p(0, 0, 1, 3'b000, 0, 0, L, 0, 3, 0, 0);
      p(1, 0, 0, 3'b000, 0, 0, I, 0, 3, 60, 0);
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);

      // Pause: updates on the pausing cycle apply, then everything is held.
      p(0, 0, 0, 3'b001, 0, 0, PL, 1, 3, 60, 0);
      p(0, 1, 0, 3'b001, 0, 0, PA, 2, 3, 60, 0);
      p(0, 0, 1, 3'b111, 1, 1, PA, 2, 3, 60, 0);
      p(0, 1, 0, 3'b000, 0, 0, PL, 2, 3, 60, 0);
      p(0, 1, 0, 3'b000, 0, 0, PA, 2, 3, 60, 0);
      p(1, 1, 0, 3'b000, 0, 0, I, 2, 3, 60, 0);   // start beats pause

      // Abort in PLAY discards that cycle's updates.
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 6, 3, 60, 0);
      p(0, 0, 1, 3'b000, 0, 0, PL, 6, 3, 59, 0);
      p(1, 0, 1, 3'b111, 0, 1, I, 6, 3, 59, 0);

      // Simultaneous win and lose resolves to WIN.
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);
      p(0, 0, 0, 3'b000, 0, 1, PL, 0, 2, 60, 0);
      p(0, 0, 0, 3'b000, 0, 1, PL, 0, 1, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 6, 1, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 12, 1, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 18, 1, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 24, 1, 60, 0);
      p(0, 0, 0, 3'b111, 0, 1, W, 30, 0, 60, 1);

      // Negative score loses.
      p(1, 0, 0, 3'b000, 0, 0, I, 0, 3, 60, 0);
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);
      p(0, 0, 0, 3'b000, 1, 0, L, -5, 3, 60, 1);

      // Mid-PLAY reset overrides everything.
      p(1, 0, 0, 3'b000, 0, 0, I, 0, 3, 60, 0);
      p(1, 0, 0, 3'b000, 0, 0, PL, 0, 3, 60, 0);
      p(0, 0, 0, 3'b111, 0, 0, PL, 6, 3, 60, 0);
      p(0, 0, 1, 3'b000, 0, 0, PL, 6, 3, 59, 0);
      drv(1'b0, 0, 0, 1, 3'b111, 1, 1, 1'b0, I, 0, 3, 60, 0);

      // Saturation on the 4-bit instance: +6, +6 clamps at 7.
      s(1, 3'b000, 0, PL, 0, 0);
      s(0, 3'b111, 0, PL, 6, 0);
      s(0, 3'b111, 0, PL, 7, 0);
      s(0, 3'b111, 0, PL, 7, 0);
      s(0, 3'b000, 1, PL, 2, 0);
      s(0, 3'b000, 1, L, -3, 1);

      repeat (3) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fruit_game_ctrl.md
Name: fruit_game_ctrl

Overview:
- Parametrised game-flow controller for the fruit-catch VGA game.
- Replaces the ad-hoc Init/Game/Win/Lose logic in the top level.
- Adds signed scoring with saturation, an N-channel fruit point table, a lives counter, a countdown timer and a pause mode.
- Sits between the debounced/one-pulsed buttons, the sprite collision logic, and the LED/7-segment/VGA consumers.

Parameters:
- N_FRUIT, 3, number of fruit channels; fruit i is worth i+1 points.
- SCORE_W, 8, score width, signed two's complement.
- WIN_SCORE, 30, score at or above which the game is won.
- BUG_PEN, 5, points subtracted per bug catch.
- LIVES, 3, lives at game start.
- LIVES_W, 2, lives counter width.
- TIME_S, 60, countdown start value in seconds.
- TIME_W, 7, timer width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-low reset.
- start_p  in  1  one-cycle start/abort pulse.
- pause_p  in  1  one-cycle pause-toggle pulse.
- sec_tick  in  1  one-cycle pulse once per second.
- fruit_hit  in  N_FRUIT  per-channel catch pulse; multiple bits may be set together.
- bug_hit  in  1  bug caught pulse.
- fruit_miss  in  1  fruit reached floor uncaught.
- state  out  3  current state encoding.
- score  out  SCORE_W  signed current score.
- lives  out  LIVES_W  remaining lives.
- time_left  out  TIME_W  seconds remaining.
- win  out  1  high while in WIN.
- over_p  out  1  one-cycle pulse on entry to WIN or LOSE.

Behaviour:
- Reset: synchronous, active-low; one clk with rst=0 applies it, overriding any operation in progress, including mid-PLAY.
- Reset values: state=IDLE, score=0, lives=LIVES, time_left=TIME_S, win=0, over_p=0.
- All outputs are registered. An event sampled at edge t is visible at edge t+1.
- States: IDLE(0), PLAY(1), PAUSE(2), WIN(3), LOSE(4).
- IDLE: on start_p, go to PLAY and load score=0, lives=LIVES, time_left=TIME_S. All other inputs are ignored.
- PLAY, each cycle:
  - gain = sum over set bits i of fruit_hit of (i+1).
  - pen = BUG_PEN if bug_hit, else 0.
  - Compute nxt = score + gain - pen at SCORE_W+2 bits, then saturate to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1].
  - lives_n = lives-1 if fruit_miss and lives>0, else lives.
  - time_n = time_left-1 if sec_tick and time_left>0, else time_left.
- PLAY transition priority (first match wins):
  1. start_p: go to IDLE, all updates discarded.
  2. nxt >= WIN_SCORE: go to WIN.
  3. nxt < 0, or lives_n == 0, or time_n == 0: go to LOSE.
  4. pause_p: go to PAUSE, updates still applied.
  5. Otherwise stay in PLAY.
- score, lives and time_left take their computed values on every PLAY cycle except abort. Final values are therefore retained in WIN/LOSE.
- PAUSE: all game inputs and sec_tick are ignored. pause_p returns to PLAY. start_p goes to IDLE; start_p takes priority over pause_p when both arrive together.
- WIN/LOSE: values are frozen. start_p goes to IDLE, with outputs taking their reset values.
- win = (state==WIN).
- over_p is high for exactly one cycle, the first cycle in WIN or LOSE.
- Boundaries:
  - Simultaneous win and lose conditions resolve to WIN.
  - lives never underflows.
  - time_left never wraps below 0.
  - Score saturates; it never wraps.

Decomposition:
- Shared package fruit_game_pkg holds: state localparams (IDLE..LOSE, 3-bit), default WIN_SCORE/BUG_PEN/LIVES/TIME_S constants, and the state width.
- One sub-module, fruit_score_acc: combinational gain/penalty summation and saturation. Parametrised by N_FRUIT, SCORE_W, BUG_PEN.
- The FSM and counters stay in fruit_game_ctrl.

Test Plan:
- Reset and start: rst=0 for 2 cycles, then start_p. Expect state=0→1, score=0, lives=3, time_left=60 at the next edge.
- Multi-hit: score=10, fruit_hit=3'b111 in one cycle. Expect score=16 next cycle. Then bug_hit gives score=11.
- Win edge: score=28, fruit_hit=3'b010. Expect score=30, state=WIN, over_p=1 for one cycle, win=1.
- Lose by misses and timer:
  - Three fruit_miss pulses: expect lives 3→2→1→0 and state=LOSE on the third.
  - Separately, 60 sec_tick pulses: expect time_left=0 and state=LOSE.
- Pause and priority:
  - pause_p, then fruit_hit and sec_tick in PAUSE: expect no change.
  - start_p together with pause_p: expect IDLE.
  - start_p together with fruit_hit in PLAY: expect IDLE with score discarded.
- Saturation and mid-game reset:
  - SCORE_W=4, WIN_SCORE=100: repeated hits clamp score at 7.
  - rst=0 mid-PLAY: expect all outputs at reset values on the next edge.
